// File: rtl/regfile_dump_reader.sv
// Streams NREGS 32-bit registers out of a register file as a little-endian
// byte stream with a valid/ready handshake, one bubble cycle between registers.
module regfile_dump_reader #(
    parameter int NREGS = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] rd_addr,
    input  logic [31:0]   rd_data,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, LATCH, SEND, DONE} state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   sh_q, sh_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            sh_q       <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            sh_q       <= sh_d;
        end
    end

    // In SEND, out_valid is always high, so out_ready alone marks a transfer.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        sh_d       = sh_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                sh_d       = rd_data;
                byte_cnt_d = 2'd0;
                state_d    = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (byte_cnt_q != 2'd3) begin
                        sh_d       = sh_q >> 8;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LATCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rd_addr   = idx_q;
        out_valid = (state_q == SEND);
        out_data  = (state_q == SEND) ? sh_q[7:0] : 8'h00;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed/randomized bench for regfile_dump_reader; expected bytes come from
// a register snapshot taken at each start, flattened little-endian into a queue.
module tb_regfile_dump_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    logic        start4;
    logic [1:0]  rd_addr4;
    logic [31:0] rd_data4;
    logic [7:0]  out_data4;
    logic        out_valid4;
    logic        busy4;
    logic        done4;

    logic [31:0] regs  [16];
    logic [31:0] regs4 [4];

    int total;
    int fails;

    assign rd_data  = regs[rd_addr];
    assign rd_data4 = regs4[rd_addr4];

    regfile_dump_reader #(.NREGS(16), .AW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    regfile_dump_reader #(.NREGS(4), .AW(2)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .start     (start4),
        .rd_addr   (rd_addr4),
        .rd_data   (rd_data4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (1'b1),
        .busy      (busy4),
        .done      (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one dump on the 16-register instance; all driving happens at negedges.
    task automatic applyStimulus(input bit rand_ready, input int restart_byte, input int reset_byte,
                                 input int mod_reg, input logic [31:0] mod_val,
                                 output int nbytes, output int ndone, output int done_edge,
                                 output bit aborted);
        logic [7:0] exp_q[$];
        int         edges;
        bit         stalled;
        bit         restarted;
        bit         modded;
        logic [7:0] stall_data;
        int         busy_low;
        for (int i = 0; i < 16; i++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'(regs[i] >> (8 * b)));
        nbytes = 0; ndone = 0; done_edge = -1; aborted = 0;
        stalled = 0; restarted = 0; modded = 0; stall_data = '0; busy_low = 0;
        start = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (stalled) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_data", 32'(out_data), 32'(stall_data));
            end
            if (done) begin
                ndone++;
                done_edge = edges - 1;
                break;
            end
            if (!busy) busy_low++;
            if (mod_reg >= 0 && !modded && out_valid && int'(rd_addr) == mod_reg) begin
                regs[mod_reg] = mod_val;
                modded = 1;
            end
            if (reset_byte >= 0 && nbytes == reset_byte && out_valid) begin
                out_ready = 1'b0;
                reset = 1'b1;
                tick();
                reset = 1'b0;
                checkOutput("abort_valid", 32'(out_valid), 32'd0);
                checkOutput("abort_busy", 32'(busy), 32'd0);
                checkOutput("abort_data", 32'(out_data), 32'd0);
                aborted = 1;
                break;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start = 1'b0;
            if (restart_byte >= 0 && !restarted && nbytes == restart_byte && out_valid) begin
                start = 1'b1;
                restarted = 1;
            end
            if (out_valid && out_ready) begin
                if (nbytes < exp_q.size()) begin
                    checkOutput("byte", 32'(out_data), 32'(exp_q[nbytes]));
                    checkOutput("rd_addr", 32'(rd_addr), 32'(nbytes / 4));
                end
                nbytes++;
            end
            stalled = out_valid && !out_ready;
            stall_data = out_data;
            tick();
            edges++;
        end
        start = 1'b0;
        if (!aborted) begin
            checkOutput("busy_through_dump", 32'(busy_low), 32'd0);
            tick();
            checkOutput("done_one_cycle", 32'(done), 32'd0);
            checkOutput("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    // Dump on the 4-register instance with out_ready tied high.
    task automatic applyStimulusSmall(output int nbytes, output int done_edge);
        logic [7:0] exp_q[$];
        int         edges;
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'(regs4[i] >> (8 * b)));
        nbytes = 0; done_edge = -1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        edges = 1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done4) begin
                done_edge = edges - 1;
                break;
            end
            if (out_valid4) begin
                if (nbytes < exp_q.size()) begin
                    checkOutput("small_byte", 32'(out_data4), 32'(exp_q[nbytes]));
                    checkOutput("small_rd_addr", 32'(rd_addr4), 32'(nbytes / 4));
                end
                nbytes++;
            end
            tick();
            edges++;
        end
        tick();
        checkOutput("small_idle", 32'(busy4), 32'd0);
    endtask

    initial begin
        int nb, nd, de;
        bit ab;
        total = 0;
        fails = 0;
        reset = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 32'h1000_0000 + 32'(i);
        for (int i = 0; i < 4; i++) regs4[i] = $urandom;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_data", 32'(out_data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_rd_addr", 32'(rd_addr), 32'd0);
        tick();
        checkOutput("idle_no_start", 32'(busy), 32'd0);

        applyStimulus(0, -1, -1, -1, 32'h0, nb, nd, de, ab);
        checkOutput("basic_count", 32'(nb), 32'd64);
        checkOutput("basic_done_count", 32'(nd), 32'd1);
        checkOutput("basic_done_edge", 32'(de), 32'd80);

        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        regs[3] = 32'hDEAD_BEEF;
        applyStimulus(1, -1, -1, -1, 32'h0, nb, nd, de, ab);
        checkOutput("stall_count", 32'(nb), 32'd64);
        checkOutput("stall_done_count", 32'(nd), 32'd1);

        tick();
        applyStimulus(0, 10, -1, -1, 32'h0, nb, nd, de, ab);
        checkOutput("restart_count", 32'(nb), 32'd64);
        checkOutput("restart_done_count", 32'(nd), 32'd1);
        checkOutput("restart_done_edge", 32'(de), 32'd80);
        tick();
        checkOutput("restart_not_queued", 32'(busy), 32'd0);

        applyStimulus(0, -1, 20, -1, 32'h0, nb, nd, de, ab);
        checkOutput("abort_flag", 32'(ab), 32'd1);
        checkOutput("abort_count", 32'(nb), 32'd20);
        tick();
        checkOutput("abort_stays_idle", 32'(out_valid), 32'd0);
        applyStimulus(0, -1, -1, -1, 32'h0, nb, nd, de, ab);
        checkOutput("post_abort_count", 32'(nb), 32'd64);
        checkOutput("post_abort_done_edge", 32'(de), 32'd80);

        regs[5] = 32'hCAFE_F00D;
        applyStimulus(1, -1, -1, 5, 32'h1234_5678, nb, nd, de, ab);
        checkOutput("mod_count", 32'(nb), 32'd64);
        tick();
        applyStimulus(0, -1, -1, -1, 32'h0, nb, nd, de, ab);
        checkOutput("mod_second_count", 32'(nb), 32'd64);
        checkOutput("mod_second_done", 32'(nd), 32'd1);

        tick();
        applyStimulusSmall(nb, de);
        checkOutput("small_count", 32'(nb), 32'd16);
        checkOutput("small_done_edge", 32'(de), 32'd20);

        $display("[TB] %0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/regfile_dump_reader.md
REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

Interface
REQ-001 SHALL provide parameter NREGS, default 16: number of registers dumped, indices 0..NREGS-1.
REQ-002 SHALL provide parameter AW, default 4: register address width; NREGS <= 2**AW.
REQ-003 SHALL provide port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL provide port start  input  1: dump request, sampled only in IDLE.
REQ-006 SHALL provide port rd_addr  output  AW: register-file read address, driven to the register file's combinational read port.
REQ-007 SHALL provide port rd_data  input  32: combinational register-file read data for rd_addr.
REQ-008 SHALL provide port out_data  output  8: byte stream data.
REQ-009 SHALL provide port out_valid  output  1: out_data valid.
REQ-010 SHALL provide port out_ready  input  1: downstream accepts the byte when out_valid is high at the same edge.
REQ-011 SHALL provide port busy  output  1: high in every state except IDLE.
REQ-012 SHALL provide port done  output  1: one-cycle pulse at dump completion.

Function
REQ-013 SHALL implement states IDLE, LATCH, SEND, DONE as a registered FSM.
REQ-014 IDLE: start=1 SHALL set idx<=0 and state<=LATCH; start=0 SHALL hold IDLE.
REQ-015 rd_addr SHALL equal idx[AW-1:0] in all states.
REQ-016 LATCH: SHALL load shift register sh<=rd_data and byte_cnt<=0, then go to SEND; exactly one cycle.
REQ-017 SEND: out_valid SHALL be 1 and out_data SHALL equal sh[7:0], byte order little-endian (bits 7:0 first, 31:24 last).
REQ-018 Handshake: a byte transfers only at an edge where out_valid=1 and out_ready=1.
REQ-019 With out_valid=1 and out_ready=0, out_data and out_valid SHALL remain stable.
REQ-020 In SEND, on a transfer with byte_cnt<3: sh<=sh>>8 and byte_cnt<=byte_cnt+1, staying in SEND.
REQ-021 In SEND, on a transfer with byte_cnt==3 and idx<NREGS-1: idx<=idx+1 and state<=LATCH.
REQ-022 In SEND, on a transfer with byte_cnt==3 and idx==NREGS-1: state<=DONE.
REQ-023 DONE: done=1 for exactly one cycle, then state<=IDLE.
REQ-024 out_valid SHALL be 0 in IDLE, LATCH and DONE, so the stream shows one bubble between registers.
REQ-025 start asserted outside IDLE SHALL be ignored and not queued.
REQ-026 start held high through DONE SHALL begin a new dump only from the IDLE cycle after DONE.
REQ-027 Total stream length SHALL be exactly 4*NREGS bytes per dump.
REQ-028 With out_ready tied to 1, done SHALL be high in the cycle after the 5*NREGS-th edge following the edge that sampled start; with NREGS=16 that is after the 80th edge.
REQ-029 rd_data SHALL be sampled only in LATCH; register-file changes after that edge SHALL NOT affect the bytes already latched.
REQ-030 idx and byte_cnt SHALL never exceed NREGS-1 and 3 respectively.

Reset
REQ-031 reset=1 at an edge SHALL force state=IDLE, idx=0, byte_cnt=0, sh=0; this takes priority over all other inputs.
REQ-032 After reset: out_valid=0, out_data=0, busy=0, done=0, rd_addr=0.
REQ-033 reset mid-dump SHALL abort with no further bytes; a pending unaccepted byte SHALL be dropped, and out_valid SHALL be 0 from the cycle after the reset edge.

Verification
REQ-034 Registers r0..r15 = 0x1000_0000+i, out_ready=1, start pulse -> 64 bytes, first four 00 00 00 10, last four 0F 00 00 10, done one cycle after the 80th edge, busy high until DONE.
REQ-035 r3=0xDEADBEEF, out_ready toggling pseudo-randomly -> bytes EF BE AD DE for r3, out_data stable during every stall, still exactly 64 transfers.
REQ-036 start pulsed again while busy (at byte 10) -> no restart, 64 bytes total, single done pulse.
REQ-037 reset asserted at byte 20 with out_valid=1, out_ready=0 -> next cycle out_valid=0, busy=0; a subsequent start gives a full 64-byte dump from r0.
REQ-038 r5 changed to 0x12345678 while r5 is in SEND (after LATCH) -> the old r5 bytes are emitted; a second dump emits 78 56 34 12.
REQ-039 NREGS=4 build, out_ready=1 -> 16 bytes, done after 20 edges, rd_addr sequence 0,1,2,3.
